// File: rtl/sm_cpu_pkg.sv
// Shared decode constants, ALU operation encoding and helpers for the sm_cpu core.
// Pure definitions; no logic or state lives here.
package sm_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_OR   = 3'd1,
    ALU_SRL  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_SUBU = 3'd4,
    ALU_LUI  = 3'd5
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/sm_cpu_if.sv
// Register-file access bundle between the sm_cpu datapath (master) and sm_register_file (slave).
// Third read port ra3/rd3 exists only when SM_CPU_DEBUG_PORT_EN is defined.
interface sm_cpu_if;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
`ifdef SM_CPU_DEBUG_PORT_EN
  logic [4:0]  ra3;
  logic [31:0] rd3;

  modport master (output ra1, ra2, wa, wd, we, ra3, input rd1, rd2, rd3);
  modport slave  (input ra1, ra2, wa, wd, we, ra3, output rd1, rd2, rd3);
`else
  modport master (output ra1, ra2, wa, wd, we, input rd1, rd2);
  modport slave  (input ra1, ra2, wa, wd, we, output rd1, rd2);
`endif
endinterface

// File: rtl/sm_register_file.sv
// 32x32 register file: asynchronous reads with $0 forced to zero, one write port on rising clk.
// Contents are deliberately not reset; SM_CPU_DEBUG_PORT_EN adds a third read port.
module sm_register_file (
  input logic     clk,
  sm_cpu_if.slave rf_if
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk) begin
    if (rf_if.we && (rf_if.wa != 5'd0)) begin
      rf[rf_if.wa] <= rf_if.wd;
    end
  end

  assign rf_if.rd1 = (rf_if.ra1 == 5'd0) ? 32'd0 : rf[rf_if.ra1];
  assign rf_if.rd2 = (rf_if.ra2 == 5'd0) ? 32'd0 : rf[rf_if.ra2];

`ifdef SM_CPU_DEBUG_PORT_EN
  assign rf_if.rd3 = (rf_if.ra3 == 5'd0) ? 32'd0 : rf[rf_if.ra3];
`endif

endmodule

// File: rtl/sm_cpu.sv
// Single-cycle MIPS-subset core: ROM fetch, decode, ALU and register reads are combinational;
// PC and the register write commit together on each rising clk. SM_CPU_DEBUG_PORT_EN adds regAddr/regData.
module sm_cpu
  import sm_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n
`ifdef SM_CPU_DEBUG_PORT_EN
  ,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData
`endif
);

  logic [31:0] rom [0:63];

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr;
  logic [31:0] pc_plus4;
  logic [31:0] imm_sext;

  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;

  logic        reg_we;
  logic        dst_sel_rd;
  logic        use_imm;
  logic        is_beq;
  logic        is_bne;
  logic        branch_taken;
  alu_op_t     alu_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] alu_res;

  sm_cpu_if rf_if ();

  sm_register_file rf (
    .clk   (clk),
    .rf_if (rf_if)
  );

  assign instr  = rom[pc_q[7:2]];
  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign imm_sext = sext16(imm);

  always_comb begin
    reg_we     = 1'b0;
    dst_sel_rd = 1'b0;
    use_imm    = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    alu_op     = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        dst_sel_rd = 1'b1;
        case (funct)
          FN_ADDU: begin reg_we = 1'b1; alu_op = ALU_ADD;  end
          FN_OR:   begin reg_we = 1'b1; alu_op = ALU_OR;   end
          FN_SRL:  begin reg_we = 1'b1; alu_op = ALU_SRL;  end
          FN_SLTU: begin reg_we = 1'b1; alu_op = ALU_SLTU; end
          FN_SUBU: begin reg_we = 1'b1; alu_op = ALU_SUBU; end
          default: ;
        endcase
      end
      OP_ADDIU: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_ADD; end
      OP_LUI:   begin reg_we = 1'b1; alu_op = ALU_LUI; end
      OP_BEQ:   is_beq = 1'b1;
      OP_BNE:   is_bne = 1'b1;
      default:  ;
    endcase
  end

  assign src_a = rf_if.rd1;
  assign src_b = use_imm ? imm_sext : rf_if.rd2;

  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_SRL:  alu_res = src_b >> shamt;
      ALU_SLTU: alu_res = {31'd0, (src_a < src_b)};
      ALU_SUBU: alu_res = src_a - src_b;
      ALU_LUI:  alu_res = {imm, 16'h0000};
      default:  alu_res = src_a + src_b;
    endcase
  end

  assign branch_taken = (is_beq && (rf_if.rd1 == rf_if.rd2)) ||
                        (is_bne && (rf_if.rd1 != rf_if.rd2));

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d = pc_plus4;
    if (branch_taken) begin
      pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign rf_if.ra1 = rs;
  assign rf_if.ra2 = rt;
  assign rf_if.wa  = dst_sel_rd ? rd : rt;
  assign rf_if.wd  = alu_res;
  // Gating with rst_n keeps the register file frozen while reset is held.
  assign rf_if.we  = reg_we & rst_n;

`ifdef SM_CPU_DEBUG_PORT_EN
  assign rf_if.ra3 = regAddr;
  assign regData   = rf_if.rd3;
`endif

endmodule

// File: tb/tb_sm_cpu.sv
// Self-checking bench for sm_cpu: expected $2 values are queued per program and popped after each edge.
module tb_sm_cpu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

`ifdef SM_CPU_DEBUG_PORT_EN
  logic [4:0]  reg_addr = 5'd2;
  logic [31:0] reg_data;
`endif

  sm_cpu dut (
    .clk     (clk),
    .rst_n   (rst_n)
`ifdef SM_CPU_DEBUG_PORT_EN
    ,
    .regAddr (reg_addr),
    .regData (reg_data)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] prog_q[$];
  logic [31:0] tmp_q[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Holds reset, loads prog_q into the ROM and seeds $0/$2; leaves reset asserted.
  task automatic load_prog(input logic [31:0] r0, input logic [31:0] r2);
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      dut.rom[i] = (i < prog_q.size()) ? prog_q[i] : 32'h0000_0000;
    end
    for (int i = 0; i < 32; i++) begin
      dut.rf.rf[i] <= 32'd0;
    end
    #1;
    dut.rf.rf[0] <= r0;
    dut.rf.rf[2] <= r2;
    #1;
  endtask

  task automatic push_exp();
    foreach (tmp_q[i]) exp_q.push_back(tmp_q[i]);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      logic [31:0] e;
      step();
      e = exp_q.pop_front();
      check(tag, dut.rf.rf[2], e);
`ifdef SM_CPU_DEBUG_PORT_EN
      check({tag, "_dbg"}, reg_data, e);
`endif
    end
  endtask

  task automatic run_prog(input string tag, input logic [31:0] r0, input logic [31:0] r2);
    load_prog(r0, r2);
    step();
    rst_n = 1'b1;
    push_exp();
    drain(tag);
  endtask

  initial begin
    // Reset: nothing executes while rst_n is low, first instruction on the first edge after release.
    prog_q = {32'h2402_0005};
    load_prog(32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rst_v0", dut.rf.rf[2], 32'd0);
      check("rst_pc", dut.pc_q, 32'd0);
    end
    rst_n = 1'b1;
    tmp_q = {32'd5};
    push_exp();
    drain("rst_first");
    check("rst_pc_after", dut.pc_q, 32'd4);

    // Immediates
    prog_q = {32'h2402_0005, 32'h2442_FFFF, 32'h3C02_1234};
    tmp_q  = {32'd5, 32'd4, 32'h1234_0000, 32'h1234_0000};
    run_prog("imm", 32'd0, 32'd0);

    // R-type with $3 = 8
    prog_q = {32'h2403_0008, 32'h0003_1082, 32'h0003_1023,
              32'h0003_102B, 32'h0062_1025, 32'h0063_1021};
    tmp_q  = {32'd0, 32'd2, 32'hFFFF_FFF8, 32'd1, 32'd9, 32'd16};
    run_prog("rtype", 32'd0, 32'd0);
    check("rtype_r3", dut.rf.rf[3], 32'd8);

    // Zero register: array garbage in $0 must read as 0 and must not be overwritten
    prog_q = {32'h2400_0007, 32'h0000_1021};
    tmp_q  = {32'h0000_0055, 32'd0};
    run_prog("zero", 32'h0000_DEAD, 32'h0000_0055);
    check("zero_r0_kept", dut.rf.rf[0], 32'h0000_DEAD);

    // Unknown funct / opcode: no write, PC still advances
    prog_q = {32'h2402_0005, 32'h0000_1020, 32'h2042_0001, 32'h2442_0001};
    tmp_q  = {32'd5, 32'd5, 32'd5, 32'd6};
    run_prog("unknown", 32'd0, 32'd0);
    check("unknown_pc", dut.pc_q, 32'd16);

    // Branch loop, interrupted by an asynchronous reset between edges
    prog_q = {32'h2402_0003, 32'h2442_FFFF, 32'h1440_FFFE, 32'h1000_FFFF};
    tmp_q  = {32'd3, 32'd2, 32'd2, 32'd1};
    run_prog("loop_pre", 32'd0, 32'd0);
    check("loop_pc_pre", dut.pc_q, 32'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_pc", dut.pc_q, 32'd0);
    check("async_keep", dut.rf.rf[2], 32'd1);
    step();
    check("async_hold", dut.rf.rf[2], 32'd1);
    rst_n = 1'b1;
    tmp_q = {32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    push_exp();
    drain("loop");
    check("loop_pc_stuck", dut.pc_q, 32'd12);
    step();
    check("loop_pc_stuck2", dut.pc_q, 32'd12);

`ifdef SM_CPU_DEBUG_PORT_EN
    reg_addr = 5'd0;
    #1;
    check("dbg_r0", reg_data, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
